gl_cmd_capture: RTL

Parametrised command-capture front end placed between the UART receiver/transmitter and the arithmetic lab unit. It assembles two multi-digit hexadecimal operands and a `+`/`-` operator from received characters, then issues a one-cycle start pulse. It echoes accepted characters and result characters through an echo FIFO that respects transmitter busy. ESC aborts the command in progress at any point.

---
 rtl/gl_cmd_pkg.sv | 28 ++
 rtl/gl_echo_fifo.sv | 71 +++++++
 rtl/gl_cmd_capture.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/gl_cmd_pkg.sv
// Shared types and character helpers for the command-capture front end.
// Decodes the +/- operator and the ESC abort character, and maps hex characters to nibbles.
package gl_cmd_pkg;

    typedef enum logic [1:0] {
        S_A  = 2'd0,
        S_B  = 2'd1,
        S_OP = 2'd2,
        S_GO = 2'd3
    } state_t;

    localparam logic [7:0] ASCII_ESC   = 8'h1B;
    localparam logic [7:0] ASCII_PLUS  = 8'h2B;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;

    // Returns {valid, nibble}; letters share low-nibble layout so upper and lower case decode alike.
    function automatic logic [4:0] hex_nibble(input logic [7:0] ch);
        logic [4:0] res;
        res = 5'd0;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            res = {1'b1, ch[3:0]};
        end else if ((ch >= 8'h61 && ch <= 8'h66) || (ch >= 8'h41 && ch <= 8'h46)) begin
            res = {1'b1, ch[3:0] + 4'd9};
        end
        return res;
    endfunction

endpackage

// File: rtl/gl_echo_fifo.sv
// Single-push/single-pop character FIFO with flush; rdata is registered and
// loads the head entry on the edge that pops it.
module gl_echo_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       resetq,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [7:0]    rdata_reg;
    logic          wr_en;
    logic          rd_en;

    assign full  = (count_reg == DEPTH_CNT);
    assign empty = (count_reg == '0);
    assign rd_en = pop && !empty;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign wr_en = push && (!full || rd_en);
    assign rdata = rdata_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            rdata_reg  <= 8'd0;
        end else begin
            if (rd_en) begin
                rdata_reg <= mem[rd_ptr_reg];
            end
            if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (wr_en) begin
                    wr_ptr_reg <= wr_ptr_reg + AW'(1);
                end
                if (rd_en) begin
                    rd_ptr_reg <= rd_ptr_reg + AW'(1);
                end
                case ({wr_en, rd_en})
                    2'b10:   count_reg <= count_reg + (AW + 1)'(1);
                    2'b01:   count_reg <= count_reg - (AW + 1)'(1);
                    default: count_reg <= count_reg;
                endcase
            end
        end
    end

endmodule

// File: rtl/gl_cmd_capture.sv
// Assembles two hex operands and a +/- operator from UART characters, issues a
// start pulse, and echoes accepted and result characters to the transmitter.
module gl_cmd_capture
    import gl_cmd_pkg::*;
#(
    parameter int DIGITS     = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                resetq,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    input  logic [7:0]          res_data,
    input  logic                res_valid,
    input  logic                tx_busy,
    output logic [7:0]          tx_data,
    output logic                tx_wr,
    output logic [4*DIGITS-1:0] op_a,
    output logic [4*DIGITS-1:0] op_b,
    output logic                op_sub,
    output logic                start,
    output logic                abort,
    output logic                ovf
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIGITS - 1);

    state_t         state_reg, state_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic [W-1:0]   shadow_a_reg, shadow_a_next;
    logic [W-1:0]   shadow_b_reg, shadow_b_next;
    logic [W-1:0]   op_a_reg, op_a_next;
    logic [W-1:0]   op_b_reg, op_b_next;
    logic           op_sub_reg, op_sub_next;
    logic           esc_dly_reg, esc_dly_next;
    logic           abort_reg, abort_next;
    logic           ovf_reg, ovf_next;
    logic           tx_wr_reg, tx_wr_next;

    logic [4:0]     hn;
    logic           is_esc;
    logic           is_op;
    logic           first_digit;
    logic           last_digit;
    logic           rx_push;
    logic           fifo_push;
    logic [7:0]     fifo_wdata;
    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [W-1:0]   acc_a;
    logic [W-1:0]   acc_b;

    assign hn          = hex_nibble(rx_data);
    assign is_esc      = rx_valid && (rx_data == ASCII_ESC);
    assign is_op       = (rx_data == ASCII_PLUS) || (rx_data == ASCII_MINUS);
    assign first_digit = (cnt_reg == '0);
    assign last_digit  = (cnt_reg == CNT_LAST);
    assign acc_a       = first_digit ? W'(hn[3:0]) : ((shadow_a_reg << 4) | W'(hn[3:0]));
    assign acc_b       = first_digit ? W'(hn[3:0]) : ((shadow_b_reg << 4) | W'(hn[3:0]));

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        shadow_a_next = shadow_a_reg;
        shadow_b_next = shadow_b_reg;
        op_a_next     = op_a_reg;
        op_b_next     = op_b_reg;
        op_sub_next   = op_sub_reg;
        rx_push       = 1'b0;

        if (is_esc) begin
            state_next    = S_A;
            cnt_next      = '0;
            shadow_a_next = '0;
            shadow_b_next = '0;
        end else begin
            case (state_reg)
                S_A: begin
                    if (rx_valid && hn[4]) begin
                        rx_push       = 1'b1;
                        shadow_a_next = acc_a;
                        cnt_next      = last_digit ? '0 : cnt_reg + CW'(1);
                        if (last_digit) begin
                            state_next = S_B;
                        end
                    end
                end
                S_B: begin
                    if (rx_valid && hn[4]) begin
                        rx_push       = 1'b1;
                        shadow_b_next = acc_b;
                        cnt_next      = last_digit ? '0 : cnt_reg + CW'(1);
                        if (last_digit) begin
                            state_next = S_OP;
                        end
                    end
                end
                S_OP: begin
                    if (rx_valid && is_op) begin
                        rx_push     = 1'b1;
                        op_a_next   = shadow_a_reg;
                        op_b_next   = shadow_b_reg;
                        op_sub_next = (rx_data == ASCII_MINUS);
                        state_next  = S_GO;
                    end
                end
                S_GO:    state_next = S_A;
                default: state_next = S_A;
            endcase
        end
    end

    // Result characters take priority over the rx echo; the losing echo counts as an overflow.
    assign fifo_push  = (rx_push || res_valid) && !is_esc;
    assign fifo_wdata = res_valid ? res_data : rx_data;
    assign fifo_pop   = !fifo_empty && !tx_busy && !tx_wr_reg;

    always_comb begin
        ovf_next = ovf_reg;
        if (is_esc) begin
            ovf_next = 1'b0;
        end else if ((rx_push && res_valid) || (fifo_push && fifo_full && !fifo_pop)) begin
            ovf_next = 1'b1;
        end
        esc_dly_next = is_esc;
        abort_next   = esc_dly_reg;
        tx_wr_next   = fifo_pop;
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_reg    <= S_A;
            cnt_reg      <= '0;
            shadow_a_reg <= '0;
            shadow_b_reg <= '0;
            op_a_reg     <= '0;
            op_b_reg     <= '0;
            op_sub_reg   <= 1'b0;
            esc_dly_reg  <= 1'b0;
            abort_reg    <= 1'b0;
            ovf_reg      <= 1'b0;
            tx_wr_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            shadow_a_reg <= shadow_a_next;
            shadow_b_reg <= shadow_b_next;
            op_a_reg     <= op_a_next;
            op_b_reg     <= op_b_next;
            op_sub_reg   <= op_sub_next;
            esc_dly_reg  <= esc_dly_next;
            abort_reg    <= abort_next;
            ovf_reg      <= ovf_next;
            tx_wr_reg    <= tx_wr_next;
        end
    end

    gl_echo_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_echo_fifo (
        .clk    (clk),
        .resetq (resetq),
        .flush  (is_esc),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .wdata  (fifo_wdata),
        .rdata  (tx_data),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign tx_wr  = tx_wr_reg;
    assign op_a   = op_a_reg;
    assign op_b   = op_b_reg;
    assign op_sub = op_sub_reg;
    assign start  = (state_reg == S_GO);
    assign abort  = abort_reg;
    assign ovf    = ovf_reg;

endmodule
